uart_word_receiver: RTL and testbench
=====================================

// Module: uart_word_receiver
// PURPOSE
//  Receive side of the APB UART. Deserialises start/data/parity/stop frames from the Rx line, oversampled by a 16x tick,
//  and assembles DATA_WIDTH-bit words LSB-first. Frames are 5-8 data bits, optional odd/even parity, 1 or 2 stops.
//  Each word closes with a one-cycle RX_done pulse and sticky error flags for the APB register block.
// PARAMETERS
//  DATA_WIDTH  32  bits per assembled word
//  OVERSAMPLE  16  rx_tick pulses per bit period; even, >=8
// PORTS
//  PCLK          in   1           system clock; all state updates on posedge
//  PRESETn       in   1           reset, asynchronous, active-low
//  rx_tick       in   1           one-PCLK enable pulse at OVERSAMPLE x baud
//  Rx            in   1           serial line, idle high, asynchronous to PCLK
//  RX_enable     in   1           level; 0 holds FSM in IDLE, discarding partial word
//  frame_length  in   4           data bits per frame: 5..8; any other value is treated as 8
//  parity_signal in   2           [1]=parity enable, [0]=1 even / 0 odd
//  stop_bits     in   1           0 = one stop bit, 1 = two stop bits
//  rx_data       out  DATA_WIDTH  last completed word; held until next RX_done
//  RX_done       out  1           one-PCLK pulse; rx_data valid in same cycle
//  RX_busy       out  1           high from first start-bit detection to RX_done
//  parity_err    out  1           any frame of the word had bad parity; valid with RX_done
//  frame_err     out  1           any sampled stop bit was 0; valid with RX_done
// BEHAVIOUR
//  Reset: FSM=IDLE; rx_data=0, RX_done=0, RX_busy=0, parity_err=0, frame_err=0; all counters 0; synchroniser flops=1.
//  Rx passes through a 2-flop synchroniser (rxs); all decisions use rxs and count rx_tick only.
//  Config (frame_length, parity_signal, stop_bits) is latched on the IDLE->START transition and held for the whole word.
//  Per-word counters: bit_idx 0..DATA_WIDTH (write position); tick_cnt 0..OVERSAMPLE-1; frame_bit 0..7.
//  States:
//   IDLE:     rxs==0 && RX_enable -> START; tick_cnt=0, bit_idx=0, clear error accumulators, RX_busy=1.
//   START:    at OVERSAMPLE/2-1 ticks (mid-bit) resample. rxs==1 -> glitch: back to IDLE
//             (or WAIT if bit_idx>0), no flag. rxs==0 -> DATA, tick_cnt=0, frame_bit=0, parity acc=0.
//   DATA:     sample at tick_cnt==OVERSAMPLE-1. If bit_idx<DATA_WIDTH, write rx_word[bit_idx]=rxs and increment
//             bit_idx; otherwise drop the bit (pad bits of the last frame). XOR into parity acc in both cases.
//             After frame_length bits: -> PARITY if enabled, else -> STOP1.
//   PARITY:   sample; expected = parity_signal[0] ? ^data : ~^data; mismatch sets parity acc error. -> STOP1.
//   STOP1:    sample; 0 sets frame error. stop_bits -> STOP2; else word end check.
//   STOP2:    sample; 0 sets frame error. -> word end check.
//   Word end check: bit_idx==DATA_WIDTH -> DONE; else -> WAIT.
//   WAIT:     rxs==0 -> START; RX_busy stays 1; no timeout.
//   DONE:     single PCLK: rx_data<=rx_word, parity_err/frame_err<=accumulators, RX_done=1 -> IDLE.
//  Frames per word = ceil(DATA_WIDTH/frame_length). E.g. 32b @5 -> 7 frames, 3 pad bits dropped; @7 -> 5 frames.
//  Latency: RX_done is asserted 1 PCLK after the rx_tick that samples the final stop bit.
//  Errors do not abort the word; the word always completes and is delivered with its flags.
//  RX_enable deassert mid-word: next PCLK -> IDLE, partial word discarded, no RX_done, RX_busy=0,
//  rx_data and flags unchanged.
//  PRESETn assert mid-word: immediate return to reset values; no RX_done.
//  rx_tick is ignored while in IDLE, WAIT, and DONE; these states react to rxs on every PCLK.
// TESTING
//  T1 len=8, no parity, 1 stop, word 32'hA5C3_1E7F sent as 4 frames -> rx_data=32'hA5C31E7F, RX_done one cycle, errs 0.
//  T2 len=5, even parity, 2 stops, word 32'hDEAD_BEEF -> 7 frames accepted, rx_data=32'hDEADBEEF, parity_err=0.
//  T3 len=7, odd parity, frame 3 parity bit inverted -> rx_data correct, parity_err=1, frame_err=0.
//  T4 len=8, frame 2 stop bit driven 0 -> RX_done after 4 frames with frame_err=1; next clean word clears flag.
//  T5 Rx low for 4 ticks then high (glitch) -> no START->DATA transition, RX_busy drops, no RX_done.
//  T6 PRESETn low during frame 2 of a word, then a clean word 32'h0000_0001 -> only the clean word is reported.

Source files
------------

// File: rtl/uart_word_receiver.sv
// uart_word_receiver
// Receive side of the APB UART. Bits are sampled from the synchronised Rx line
// using a 16x oversampling tick. Each frame carries 5-8 data bits, an optional
// odd/even parity bit and 1 or 2 stop bits. Data bits are packed LSB-first into
// DATA_WIDTH-bit words. When a word is complete, RX_done pulses for one cycle.
// The error flags are sticky: each is set if any frame of the word had that error.
module uart_word_receiver #(
    parameter int DATA_WIDTH = 32,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  rx_tick,
    input  logic                  Rx,
    input  logic                  RX_enable,
    input  logic [3:0]            frame_length,
    input  logic [1:0]            parity_signal,
    input  logic                  stop_bits,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  RX_done,
    output logic                  RX_busy,
    output logic                  parity_err,
    output logic                  frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] WORD_END  = BW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_WAIT   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t state_q, state_d;

    logic                  rx_meta_q, rxs_q;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [2:0]            frame_bit_q, frame_bit_d;
    logic [DATA_WIDTH-1:0] rx_word_q, rx_word_d;
    logic                  par_acc_q, par_acc_d;
    logic                  perr_acc_q, perr_acc_d;
    logic                  ferr_acc_q, ferr_acc_d;
    logic [3:0]            len_q, len_d;
    logic                  par_en_q, par_en_d;
    logic                  par_even_q, par_even_d;
    logic                  stop2_q, stop2_d;

    logic                  sample;
    logic                  load_out;
    logic                  exp_par;
    logic [3:0]            len_norm;
    state_t                end_state;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // Legal frame lengths pass through unchanged; anything else behaves as 8.
    always_comb begin
        len_norm = 4'd8;
        if (frame_length >= 4'd5 && frame_length <= 4'd8)
            len_norm = frame_length;
    end

    assign sample    = rx_tick && (tick_cnt_q == TICK_LAST);
    assign exp_par   = par_even_q ? par_acc_q : ~par_acc_q;
    assign end_state = (bit_idx_q == WORD_END) ? S_DONE : S_WAIT;

    // Next-state and datapath update logic for the receive FSM.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        frame_bit_d = frame_bit_q;
        rx_word_d   = rx_word_q;
        par_acc_d   = par_acc_q;
        perr_acc_d  = perr_acc_q;
        ferr_acc_d  = ferr_acc_q;
        len_d       = len_q;
        par_en_d    = par_en_q;
        par_even_d  = par_even_q;
        stop2_d     = stop2_q;

        case (state_q)
            S_IDLE: begin
                if (RX_enable && !rxs_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    rx_word_d  = '0;
                    perr_acc_d = 1'b0;
                    ferr_acc_d = 1'b0;
                    len_d      = len_norm;
                    par_en_d   = parity_signal[1];
                    par_even_d = parity_signal[0];
                    stop2_d    = stop_bits;
                end
            end
            S_START: begin
                if (rx_tick) begin
                    if (tick_cnt_q == TICK_HALF) begin
                        tick_cnt_d = '0;
                        if (rxs_q) begin
                            // Line went back high before mid-bit: glitch, not a start.
                            state_d = (bit_idx_q == '0) ? S_IDLE : S_WAIT;
                        end else begin
                            state_d     = S_DATA;
                            frame_bit_d = '0;
                            par_acc_d   = 1'b0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (rx_tick)
                    tick_cnt_d = sample ? '0 : tick_cnt_q + 1'b1;
                if (sample) begin
                    // Bits past the end of the word are pad bits: counted in parity only.
                    if (bit_idx_q < WORD_END) begin
                        rx_word_d[bit_idx_q[IW-1:0]] = rxs_q;
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                    par_acc_d = par_acc_q ^ rxs_q;
                    if ({1'b0, frame_bit_q} == (len_q - 4'd1))
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    else
                        frame_bit_d = frame_bit_q + 1'b1;
                end
            end
            S_PARITY: begin
                if (rx_tick)
                    tick_cnt_d = sample ? '0 : tick_cnt_q + 1'b1;
                if (sample) begin
                    if (rxs_q != exp_par)
                        perr_acc_d = 1'b1;
                    state_d = S_STOP1;
                end
            end
            S_STOP1: begin
                if (rx_tick)
                    tick_cnt_d = sample ? '0 : tick_cnt_q + 1'b1;
                if (sample) begin
                    if (!rxs_q)
                        ferr_acc_d = 1'b1;
                    state_d = stop2_q ? S_STOP2 : end_state;
                end
            end
            S_STOP2: begin
                if (rx_tick)
                    tick_cnt_d = sample ? '0 : tick_cnt_q + 1'b1;
                if (sample) begin
                    if (!rxs_q)
                        ferr_acc_d = 1'b1;
                    state_d = end_state;
                end
            end
            S_WAIT: begin
                if (!rxs_q) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disabling the receiver abandons any partial word immediately.
        if (!RX_enable)
            state_d = S_IDLE;
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Per-word counters, word assembly and latched frame configuration.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            frame_bit_q <= '0;
            rx_word_q   <= '0;
            par_acc_q   <= 1'b0;
            perr_acc_q  <= 1'b0;
            ferr_acc_q  <= 1'b0;
            len_q       <= 4'd8;
            par_en_q    <= 1'b0;
            par_even_q  <= 1'b0;
            stop2_q     <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            frame_bit_q <= frame_bit_d;
            rx_word_q   <= rx_word_d;
            par_acc_q   <= par_acc_d;
            perr_acc_q  <= perr_acc_d;
            ferr_acc_q  <= ferr_acc_d;
            len_q       <= len_d;
            par_en_q    <= par_en_d;
            par_even_q  <= par_even_d;
            stop2_q     <= stop2_d;
        end
    end

    // Outputs are loaded on entry to DONE, so they are valid together with RX_done.
    assign load_out = (state_d == S_DONE) && (state_q != S_DONE);

    // Delivered word and error flags, held until the next completed word.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else if (load_out) begin
            rx_data    <= rx_word_d;
            parity_err <= perr_acc_d;
            frame_err  <= ferr_acc_d;
        end
    end

    assign RX_done = (state_q == S_DONE);
    assign RX_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_word_receiver.sv
// tb_uart_word_receiver
// Drives randomized and directed UART words into uart_word_receiver.
// Delivered words and flags are compared against values that the bench
// derives from the words and fault injections it chose.
module tb_uart_word_receiver;

    localparam int BIT = 32;  // PCLK cycles per bit: 16 ticks, one tick every 2 PCLK

    logic        PCLK;
    logic        PRESETn;
    logic        rx_tick;
    logic        Rx;
    logic        RX_enable;
    logic [3:0]  frame_length;
    logic [1:0]  parity_signal;
    logic        stop_bits;
    logic [31:0] rx_data;
    logic        RX_done;
    logic        RX_busy;
    logic        parity_err;
    logic        frame_err;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          long_pulse = 0;
    logic        done_prev = 1'b0;
    logic [31:0] last_data = '0;
    logic        last_pe = 1'b0;
    logic        last_fe = 1'b0;

    uart_word_receiver #(.DATA_WIDTH(32), .OVERSAMPLE(16)) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .rx_tick       (rx_tick),
        .Rx            (Rx),
        .RX_enable     (RX_enable),
        .frame_length  (frame_length),
        .parity_signal (parity_signal),
        .stop_bits     (stop_bits),
        .rx_data       (rx_data),
        .RX_done       (RX_done),
        .RX_busy       (RX_busy),
        .parity_err    (parity_err),
        .frame_err     (frame_err)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Oversampling tick: one PCLK high every second cycle.
    initial begin
        rx_tick = 1'b0;
        forever begin
            @(negedge PCLK);
            rx_tick = ~rx_tick;
        end
    end

    // Capture every completed word and look for stretched RX_done pulses.
    initial begin
        forever begin
            @(negedge PCLK);
            if (RX_done) begin
                done_cnt++;
                last_data = rx_data;
                last_pe   = parity_err;
                last_fe   = frame_err;
                if (done_prev)
                    long_pulse++;
            end
            done_prev = RX_done;
        end
    end

    // Hard bound on total run time.
    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        Rx = b;
        repeat (n) @(negedge PCLK);
    endtask

    // One frame. bad_stop: 0 none, 1 first stop low, 2 second stop low.
    // A stop bit driven low is low only around mid-bit. An extra idle gap
    // follows it so that the low level is not taken as the next start bit.
    task automatic send_frame(input logic [7:0] d, input int len, input logic pen,
                              input logic peven, input logic s2, input logic bad_par,
                              input int bad_stop, input int gap);
        logic p;
        p = 1'b0;
        drive(1'b0, BIT);
        for (int i = 0; i < len; i++) begin
            drive(d[i], BIT);
            p = p ^ d[i];
        end
        if (pen) begin
            if (!peven) p = ~p;
            if (bad_par) p = ~p;
            drive(p, BIT);
        end
        if (bad_stop == 1) begin drive(1'b1, 12); drive(1'b0, 12); drive(1'b1, 8); end
        else drive(1'b1, BIT);
        if (s2) begin
            if (bad_stop == 2) begin drive(1'b1, 12); drive(1'b0, 12); drive(1'b1, 8); end
            else drive(1'b1, BIT);
        end
        drive(1'b1, gap + ((bad_stop != 0) ? 40 : 0));
    endtask

    // Send a whole word. Bits past bit 31 in the last frame are random padding.
    task automatic send_word(input logic [31:0] w, input logic [3:0] fl, input logic [1:0] ps,
                             input logic sb, input int bad_par_frame, input int bad_stop_frame,
                             output logic exp_pe, output logic exp_fe);
        int          len;
        int          nfr;
        int          idx;
        int          bs;
        logic [7:0]  d;
        frame_length  = fl;
        parity_signal = ps;
        stop_bits     = sb;
        len = (fl >= 4'd5 && fl <= 4'd8) ? int'(fl) : 8;
        nfr = (32 + len - 1) / len;
        exp_pe = ps[1] && (bad_par_frame >= 0) && (bad_par_frame < nfr);
        exp_fe = (bad_stop_frame >= 0) && (bad_stop_frame < nfr);
        for (int f = 0; f < nfr; f++) begin
            d = '0;
            for (int i = 0; i < len; i++) begin
                idx = f * len + i;
                d[i] = (idx < 32) ? w[idx] : 1'($urandom_range(0, 1));
            end
            bs = 0;
            if (f == bad_stop_frame)
                bs = sb ? int'($urandom_range(1, 2)) : 1;
            send_frame(d, len, ps[1], ps[0], sb, (f == bad_par_frame), bs,
                       int'($urandom_range(0, 10)));
        end
    endtask

    task automatic do_word(input string tag, input logic [31:0] w, input logic [3:0] fl,
                           input logic [1:0] ps, input logic sb, input int bpf, input int bsf);
        int   prev;
        int   n;
        logic epe;
        logic efe;
        prev = done_cnt;
        send_word(w, fl, ps, sb, bpf, bsf, epe, efe);
        n = 0;
        while (done_cnt == prev && n < 400) begin
            @(negedge PCLK);
            n++;
        end
        check_eq({tag, "_done_count"}, 32'(done_cnt - prev), 32'd1);
        check_eq({tag, "_data"}, last_data, w);
        check_eq({tag, "_parity_err"}, {31'd0, last_pe}, {31'd0, epe});
        check_eq({tag, "_frame_err"}, {31'd0, last_fe}, {31'd0, efe});
        drive(1'b1, 60);
        check_eq({tag, "_busy_after"}, {31'd0, RX_busy}, 32'd0);
    endtask

    initial begin
        int          prev;
        logic [31:0] held;
        logic [3:0]  fl_tab [6];
        fl_tab = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd12};

        PRESETn       = 1'b0;
        Rx            = 1'b1;
        RX_enable     = 1'b1;
        frame_length  = 4'd8;
        parity_signal = 2'b00;
        stop_bits     = 1'b0;
        repeat (5) @(negedge PCLK);
        check_eq("reset_data", rx_data, 32'd0);
        check_eq("reset_done", {31'd0, RX_done}, 32'd0);
        check_eq("reset_busy", {31'd0, RX_busy}, 32'd0);
        check_eq("reset_perr", {31'd0, parity_err}, 32'd0);
        check_eq("reset_ferr", {31'd0, frame_err}, 32'd0);
        PRESETn = 1'b1;
        repeat (5) @(negedge PCLK);

        do_word("t1", 32'hA5C3_1E7F, 4'd8, 2'b00, 1'b0, -1, -1);
        do_word("t2", 32'hDEAD_BEEF, 4'd5, 2'b11, 1'b1, -1, -1);
        do_word("t3", 32'h1357_9BDF, 4'd7, 2'b10, 1'b0, 3, -1);
        do_word("t4", 32'h0F0F_55AA, 4'd8, 2'b00, 1'b0, -1, 2);
        do_word("t4_clean", 32'hC001_D00D, 4'd8, 2'b00, 1'b0, -1, -1);

        // Short low pulse on the line: not a start bit.
        prev = done_cnt;
        held = rx_data;
        Rx = 1'b0;
        repeat (5) @(negedge PCLK);
        check_eq("t5_busy_during", {31'd0, RX_busy}, 32'd1);
        repeat (3) @(negedge PCLK);
        drive(1'b1, 60);
        check_eq("t5_busy_after", {31'd0, RX_busy}, 32'd0);
        check_eq("t5_no_done", 32'(done_cnt - prev), 32'd0);
        check_eq("t5_data_held", rx_data, held);

        // Receiver disabled partway through a word.
        prev = done_cnt;
        held = rx_data;
        frame_length = 4'd8; parity_signal = 2'b00; stop_bits = 1'b0;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        send_frame(8'hA1, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 3 * BIT);
        RX_enable = 1'b0;
        repeat (2) @(negedge PCLK);
        check_eq("en_busy_drop", {31'd0, RX_busy}, 32'd0);
        drive(1'b1, 2 * BIT);
        RX_enable = 1'b1;
        drive(1'b1, 20);
        check_eq("en_no_done", 32'(done_cnt - prev), 32'd0);
        check_eq("en_data_held", rx_data, held);
        do_word("en_after", 32'h8421_7BDE, 4'd6, 2'b11, 1'b0, -1, -1);

        // Reset asserted during frame 2, then a clean word.
        prev = done_cnt;
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 2 * BIT);
        PRESETn = 1'b0;
        Rx = 1'b1;
        @(negedge PCLK);
        check_eq("t6_reset_data", rx_data, 32'd0);
        check_eq("t6_reset_busy", {31'd0, RX_busy}, 32'd0);
        repeat (5) @(negedge PCLK);
        PRESETn = 1'b1;
        drive(1'b1, 10);
        check_eq("t6_no_done", 32'(done_cnt - prev), 32'd0);
        do_word("t6_clean", 32'h0000_0001, 4'd8, 2'b00, 1'b0, -1, -1);

        // Random words, configurations and fault injections.
        for (int k = 0; k < 8; k++) begin
            logic [3:0] fl;
            logic [1:0] ps;
            logic       sb;
            int         bpf;
            int         bsf;
            fl  = fl_tab[$urandom_range(0, 5)];
            ps  = 2'($urandom_range(0, 3));
            sb  = 1'($urandom_range(0, 1));
            bpf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            bsf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_word($sformatf("rand%0d", k), $urandom, fl, ps, sb, bpf, bsf);
        end

        check_eq("done_single_cycle", 32'(long_pulse), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
